// File: rtl/conv_sched.sv
// Convolution job scheduler: sequences window fetches, accumulates CONV groups, and hands results downstream.
// Optional macro CONV_SCHED_SAT_EN: saturate the CONV-mode accumulator at 1023 instead of wrapping.
module conv_sched (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_start,
   input  logic        i_mode,
   input  logic [15:0] i_numPix,
   input  logic [3:0]  i_numGrp,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_winReq,
   input  logic        i_winVld,
   output logic [15:0] o_pixIdx,
   output logic [3:0]  o_grpIdx,
   output logic        o_opcode,
   input  logic [9:0]  i_conv0,
   input  logic [9:0]  i_conv1,
   input  logic [9:0]  i_conv2,
   output logic        o_vld,
   input  logic        i_rdy,
   output logic [9:0]  o_data0,
   output logic [9:0]  o_data1,
   output logic [9:0]  o_data2
);

   typedef enum logic [1:0] {IDLE, FETCH, OUT, DONE} state_t;

   state_t      state_reg,   state_next;
   logic        mode_reg,    mode_next;
   logic [15:0] num_pix_reg, num_pix_next;
   logic [3:0]  num_grp_reg, num_grp_next;
   logic [15:0] pix_idx_reg, pix_idx_next;
   logic [3:0]  grp_idx_reg, grp_idx_next;
   logic [9:0]  acc_reg,     acc_next;
   logic [9:0]  data0_reg,   data0_next;
   logic [9:0]  data1_reg,   data1_next;
   logic [9:0]  data2_reg,   data2_next;

   logic [10:0] acc_sum;
   logic [9:0]  acc_add;
   logic        last_grp;
   logic        last_pix;

   // Sum carried one bit wider so saturation can see the overflow.
   assign acc_sum = {1'b0, acc_reg} + {1'b0, i_conv0};
`ifdef CONV_SCHED_SAT_EN
   assign acc_add = acc_sum[10] ? 10'h3FF : acc_sum[9:0];
`else
   assign acc_add = acc_sum[9:0];
`endif

   // num_grp_reg always holds 1..15, so the subtraction cannot wrap.
   assign last_grp = (grp_idx_reg == num_grp_reg - 4'd1);
   assign last_pix = (pix_idx_reg == num_pix_reg - 16'd1);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_reg   <= IDLE;
         mode_reg    <= 1'b0;
         num_pix_reg <= 16'd0;
         num_grp_reg <= 4'd0;
         pix_idx_reg <= 16'd0;
         grp_idx_reg <= 4'd0;
         acc_reg     <= 10'd0;
         data0_reg   <= 10'd0;
         data1_reg   <= 10'd0;
         data2_reg   <= 10'd0;
      end else begin
         state_reg   <= state_next;
         mode_reg    <= mode_next;
         num_pix_reg <= num_pix_next;
         num_grp_reg <= num_grp_next;
         pix_idx_reg <= pix_idx_next;
         grp_idx_reg <= grp_idx_next;
         acc_reg     <= acc_next;
         data0_reg   <= data0_next;
         data1_reg   <= data1_next;
         data2_reg   <= data2_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      mode_next    = mode_reg;
      num_pix_next = num_pix_reg;
      num_grp_next = num_grp_reg;
      pix_idx_next = pix_idx_reg;
      grp_idx_next = grp_idx_reg;
      acc_next     = acc_reg;
      data0_next   = data0_reg;
      data1_next   = data1_reg;
      data2_next   = data2_reg;

      case (state_reg)
         IDLE: begin
            if (i_start) begin
               mode_next    = i_mode;
               num_pix_next = i_numPix;
               num_grp_next = (i_numGrp == 4'd0) ? 4'd1 : i_numGrp;
               pix_idx_next = 16'd0;
               grp_idx_next = 4'd0;
               acc_next     = 10'd0;
               state_next   = (i_numPix == 16'd0) ? DONE : FETCH;
            end
         end
         FETCH: begin
            if (i_winVld) begin
               if (!mode_reg) begin
                  data0_next = i_conv0;
                  data1_next = i_conv1;
                  data2_next = i_conv2;
                  state_next = OUT;
               end else begin
                  acc_next = acc_add;
                  if (last_grp) begin
                     data0_next = acc_add;
                     data1_next = 10'd0;
                     data2_next = 10'd0;
                     state_next = OUT;
                  end else begin
                     grp_idx_next = grp_idx_reg + 4'd1;
                  end
               end
            end
         end
         OUT: begin
            if (i_rdy) begin
               if (last_pix) begin
                  state_next = DONE;
               end else begin
                  pix_idx_next = pix_idx_reg + 16'd1;
                  grp_idx_next = 4'd0;
                  acc_next     = 10'd0;
                  state_next   = FETCH;
               end
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Handshake strobes decode straight from the state, so o_winReq and o_vld are exclusive.
   assign o_busy   = (state_reg != IDLE);
   assign o_done   = (state_reg == DONE);
   assign o_winReq = (state_reg == FETCH);
   assign o_vld    = (state_reg == OUT);
   assign o_opcode = mode_reg;
   assign o_pixIdx = pix_idx_reg;
   assign o_grpIdx = grp_idx_reg;
   assign o_data0  = data0_reg;
   assign o_data1  = data1_reg;
   assign o_data2  = data2_reg;

endmodule

// File: tb/tb_conv_sched.sv
// Directed self-checking bench for conv_sched; expected values are hand-computed per scenario.
module tb_conv_sched;

   logic        i_clk;
   logic        i_rst_n;
   logic        i_start;
   logic        i_mode;
   logic [15:0] i_numPix;
   logic [3:0]  i_numGrp;
   logic        o_busy;
   logic        o_done;
   logic        o_winReq;
   logic        i_winVld;
   logic [15:0] o_pixIdx;
   logic [3:0]  o_grpIdx;
   logic        o_opcode;
   logic [9:0]  i_conv0;
   logic [9:0]  i_conv1;
   logic [9:0]  i_conv2;
   logic        o_vld;
   logic        i_rdy;
   logic [9:0]  o_data0;
   logic [9:0]  o_data1;
   logic [9:0]  o_data2;

   int chk_cnt  = 0;
   int pass_cnt = 0;
   int done_seen = 0;
   int overlap_cnt = 0;
   logic watch_done = 1'b0;

   conv_sched dut (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_start  (i_start),
      .i_mode   (i_mode),
      .i_numPix (i_numPix),
      .i_numGrp (i_numGrp),
      .o_busy   (o_busy),
      .o_done   (o_done),
      .o_winReq (o_winReq),
      .i_winVld (i_winVld),
      .o_pixIdx (o_pixIdx),
      .o_grpIdx (o_grpIdx),
      .o_opcode (o_opcode),
      .i_conv0  (i_conv0),
      .i_conv1  (i_conv1),
      .i_conv2  (i_conv2),
      .o_vld    (o_vld),
      .i_rdy    (i_rdy),
      .o_data0  (o_data0),
      .o_data1  (o_data1),
      .o_data2  (o_data2)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   always @(negedge i_clk) begin
      if (watch_done && o_done) done_seen++;
      if (o_winReq && o_vld) overlap_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs === exp) begin
         pass_cnt++;
         $display("check %-16s obs=%0d exp=%0d ok", tag, obs, exp);
      end else begin
         $display("FAIL %-16s obs=%0d exp=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic start_job(input logic mode, input logic [15:0] npix, input logic [3:0] ngrp);
      i_mode   = mode;
      i_numPix = npix;
      i_numGrp = ngrp;
      i_start  = 1'b1;
      tick();
      i_start  = 1'b0;
   endtask

   logic [9:0] exp_sat;

   initial begin
`ifdef CONV_SCHED_SAT_EN
      exp_sat = 10'd1023;
`else
      exp_sat = 10'd776;
`endif
      i_rst_n  = 1'b0;
      i_start  = 1'b0;
      i_mode   = 1'b0;
      i_numPix = 16'd0;
      i_numGrp = 4'd0;
      i_winVld = 1'b0;
      i_rdy    = 1'b0;
      i_conv0  = 10'd0;
      i_conv1  = 10'd0;
      i_conv2  = 10'd0;
      tick();
      tick();
      check("rst_busy",   32'(o_busy),   0);
      check("rst_done",   32'(o_done),   0);
      check("rst_winreq", 32'(o_winReq), 0);
      check("rst_vld",    32'(o_vld),    0);
      check("rst_data0",  32'(o_data0),  0);
      i_rst_n = 1'b1;
      tick();

      // Depthwise, two pixels, always valid/ready.
      i_winVld = 1'b1;
      i_rdy    = 1'b1;
      i_conv0  = 10'd5;
      i_conv1  = 10'd6;
      i_conv2  = 10'd7;
      start_job(1'b0, 16'd2, 4'd0);
      check("dw_fetch_req", 32'(o_winReq), 1);
      check("dw_busy",      32'(o_busy),   1);
      tick();
      check("dw_out0_vld",  32'(o_vld),    1);
      check("dw_out0_d0",   32'(o_data0),  5);
      check("dw_out0_d1",   32'(o_data1),  6);
      check("dw_out0_d2",   32'(o_data2),  7);
      check("dw_out0_op",   32'(o_opcode), 0);
      check("dw_out0_req",  32'(o_winReq), 0);
      tick();
      check("dw_fetch1",    32'(o_winReq), 1);
      check("dw_pix1",      32'(o_pixIdx), 1);
      tick();
      check("dw_out1_vld",  32'(o_vld),    1);
      check("dw_out1_d",    32'({o_data0, o_data1, o_data2}), 32'({10'd5, 10'd6, 10'd7}));
      tick();
      check("dw_done",      32'(o_done),   1);
      tick();
      check("dw_done_clr",  32'(o_done),   0);
      check("dw_idle_busy", 32'(o_busy),   0);

      // CONV, one pixel, three groups of 100; starts right in the IDLE cycle after DONE.
      i_conv0 = 10'd100;
      start_job(1'b1, 16'd1, 4'd3);
      check("cv_g0_req",    32'(o_winReq), 1);
      check("cv_g0_idx",    32'(o_grpIdx), 0);
      tick();
      check("cv_g1_req",    32'(o_winReq), 1);
      check("cv_g1_idx",    32'(o_grpIdx), 1);
      tick();
      check("cv_g2_req",    32'(o_winReq), 1);
      check("cv_g2_idx",    32'(o_grpIdx), 2);
      tick();
      check("cv_vld",       32'(o_vld),    1);
      check("cv_d0",        32'(o_data0),  300);
      check("cv_d1",        32'(o_data1),  0);
      check("cv_d2",        32'(o_data2),  0);
      check("cv_op",        32'(o_opcode), 1);
      tick();
      check("cv_done",      32'(o_done),   1);
      tick();

      // CONV overflow: 3 x 600.
      i_conv0 = 10'd600;
      start_job(1'b1, 16'd1, 4'd3);
      tick();
      tick();
      tick();
      check("ovf_vld",      32'(o_vld),    1);
      check("ovf_d0",       32'(o_data0),  32'(exp_sat));
      tick();
      check("ovf_done",     32'(o_done),   1);
      tick();

      // Depthwise stall: downstream not ready for 5 cycles; a stray start must be ignored.
      i_rdy   = 1'b0;
      i_conv0 = 10'd11;
      i_conv1 = 10'd22;
      i_conv2 = 10'd33;
      start_job(1'b0, 16'd1, 4'd0);
      tick();
      i_conv0 = 10'd1;
      i_conv1 = 10'd2;
      i_conv2 = 10'd3;
      i_start = 1'b1;
      i_mode  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("stl_vld",   32'(o_vld),    1);
         check("stl_req",   32'(o_winReq), 0);
         check("stl_data",  32'({o_data0, o_data1, o_data2}), 32'({10'd11, 10'd22, 10'd33}));
         check("stl_op",    32'(o_opcode), 0);
         if (i < 4) tick();
      end
      i_start = 1'b0;
      i_rdy   = 1'b1;
      tick();
      check("stl_done",     32'(o_done),   1);
      tick();
      check("stl_idle",     32'(o_busy),   0);

      // Mid-job reset during pixel 1 fetch of a 4-pixel CONV job.
      i_conv0 = 10'd50;
      watch_done = 1'b1;
      start_job(1'b1, 16'd4, 4'd2);
      tick();
      tick();
      check("mr_out_d0",    32'(o_data0),  100);
      tick();
      check("mr_pix1_req",  32'(o_winReq), 1);
      check("mr_pix1_idx",  32'(o_pixIdx), 1);
      i_rst_n = 1'b0;
      #1;
      check("mr_busy",      32'(o_busy),   0);
      check("mr_req",       32'(o_winReq), 0);
      check("mr_vld",       32'(o_vld),    0);
      check("mr_op",        32'(o_opcode), 0);
      check("mr_pix",       32'(o_pixIdx), 0);
      check("mr_data0",     32'(o_data0),  0);
      tick();
      i_rst_n = 1'b1;
      tick();
      tick();
      check("mr_no_resume", 32'({o_busy, o_winReq}), 0);
      check("mr_no_done",   32'(done_seen), 0);
      watch_done = 1'b0;
      start_job(1'b0, 16'd0, 4'd0);
      check("np0_done",     32'(o_done),   1);
      check("np0_req",      32'(o_winReq), 0);
      tick();
      check("np0_done_clr", 32'(o_done),   0);
      check("excl_req_vld", 32'(overlap_cnt), 0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/conv_sched.md
CONV_SCHED -- requirements
Module: conv_sched

Interface
REQ-001 SHALL have port i_clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port i_start, input, 1 bit: job start; sampled only in IDLE.
REQ-004 SHALL have port i_mode, input, 1 bit: 1 = standard CONV (3-channel sum); 0 = depthwise (3 independent channels).
REQ-005 SHALL have port i_numPix, input, 16 bits: output pixels per job; 0 = no pixels.
REQ-006 SHALL have port i_numGrp, input, 4 bits: 3-channel groups per pixel, CONV mode only; 0 is treated as 1.
REQ-007 SHALL have port o_busy, output, 1 bit: high from job acceptance until o_done.
REQ-008 SHALL have port o_done, output, 1 bit: one-cycle pulse at job end.
REQ-009 SHALL have port o_winReq, output, 1 bit: request to the window/weight buffer to drive the datapath buses.
REQ-010 SHALL have port i_winVld, input, 1 bit: buses valid; a fetch completes when o_winReq and i_winVld are both high.
REQ-011 SHALL have port o_pixIdx, output, 16 bits: current pixel index.
REQ-012 SHALL have port o_grpIdx, output, 4 bits: current group index.
REQ-013 SHALL have port o_opcode, output, 1 bit: datapath select; equals the latched mode.
REQ-014 SHALL have ports i_conv0, i_conv1, i_conv2, input, 10 bits each: combinational datapath results.
REQ-015 SHALL have port o_vld, output, 1 bit: output result valid.
REQ-016 SHALL have port i_rdy, input, 1 bit: downstream ready.
REQ-017 SHALL have ports o_data0, o_data1, o_data2, output, 10 bits each: registered results.

Function
REQ-018 SHALL implement FSM states IDLE, FETCH, OUT, DONE.
REQ-019 IDLE with i_start=1 SHALL latch i_mode, i_numPix and i_numGrp, clear the indices and accumulator, and go to FETCH.
  - If i_numPix=0, it SHALL go to DONE instead.
REQ-020 FETCH SHALL hold o_winReq=1 until the handshake; i_conv* SHALL be sampled in the handshake cycle.
REQ-021 Depthwise mode, on handshake: o_data0..2 <= i_conv0..2; next state OUT.
REQ-022 CONV mode, on handshake: acc <= acc + i_conv0 (10-bit unsigned).
  - Not the last group: o_grpIdx increments; state stays FETCH with o_winReq=1 on the next cycle.
  - Last group: o_data0 <= acc + i_conv0, o_data1 = o_data2 = 0; next state OUT.
REQ-023 OUT SHALL hold o_vld=1 and o_data* stable until i_rdy=1.
  - On o_vld&i_rdy with pixels remaining: o_pixIdx increments, o_grpIdx and acc clear, next state FETCH.
  - On the last pixel: next state DONE.
REQ-024 DONE SHALL assert o_done for exactly one cycle, then return to IDLE; o_busy SHALL be low in IDLE.
REQ-025 o_winReq and o_vld SHALL never be high in the same cycle.
REQ-026 i_start outside IDLE SHALL be ignored.
REQ-027 Back-to-back jobs: i_start in the IDLE cycle immediately after DONE SHALL be accepted.
REQ-028 Minimum latency per pixel SHALL be numGrp fetch cycles plus 1 OUT cycle (depthwise: 2 cycles).

Reset
REQ-029 Reset assertion SHALL immediately force IDLE, including mid-job.
  - Outputs forced to 0: o_busy, o_done, o_winReq, o_vld, o_opcode, o_pixIdx, o_grpIdx, o_data0..2.
  - Accumulator and latched config forced to 0.
REQ-030 After reset deassertion, the block SHALL require a fresh i_start; no partial job resumes.

Configuration
REQ-031 Macro CONV_SCHED_SAT_EN SHALL select accumulator overflow behaviour.
  - Defined: CONV-mode accumulation saturates at 1023.
  - Undefined: accumulation wraps modulo 1024.
  - Depthwise behaviour SHALL be identical either way.

Verification
REQ-032 Depthwise, numPix=2, i_winVld=1, i_rdy=1, i_conv=(5,6,7):
  - Two OUT beats with o_data=(5,6,7) and o_opcode=0.
  - o_done exactly 4 cycles after the FETCH entry.
REQ-033 CONV, numPix=1, numGrp=3, i_conv0=100 each fetch:
  - Exactly 3 o_winReq handshakes with o_grpIdx=0,1,2.
  - o_data0=300, o_data1=o_data2=0, o_opcode=1.
REQ-034 CONV, numGrp=3, i_conv0=600:
  - With CONV_SCHED_SAT_EN: o_data0=1023.
  - Without it: o_data0=(1800 mod 1024)=776.
REQ-035 Depthwise, numPix=1, i_rdy held 0 for 5 cycles:
  - o_vld stays high and o_data stays stable for those 5 cycles.
  - No o_winReq during the stall.
  - o_done follows one cycle after i_rdy rises.
REQ-036 Mid-job reset (CONV, numPix=4, i_rst_n low during pixel 2 FETCH):
  - All outputs 0 immediately.
  - o_done never pulses.
  - A subsequent i_start with numPix=0 produces o_done on the second cycle and no o_winReq.
